// File: rtl/cpu_pkg.sv
// Shared CPU definitions: divider FSM state encoding and default divider sizing.
package cpu_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem, quo} left by one,
// trial-subtract the divisor, keep the difference and set the quotient bit if non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // quo_in holds the not-yet-consumed dividend bits in its upper part.
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};

  always_comb begin
    if (!trial[WIDTH]) begin
      rem_out = trial[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end else begin
      rem_out = shifted[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU (one quotient bit per cycle).
// Optional DIV_ZERO_FAST_EN: divide-by-zero completes one cycle after start and raises div_zero.
module div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output div_state_t       state_dbg
`ifdef DIV_ZERO_FAST_EN
  ,
  output logic             div_zero
`endif
);

  div_state_t       state, state_nxt;
  logic [WIDTH-1:0] rem_q, quo_q, div_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_quo, neg_rem, dz_q;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             a_neg, b_neg, zero_in, fast_zero, accept, last_iter;

  assign a_neg     = is_signed & dividend[WIDTH-1];
  assign b_neg     = is_signed & divisor[WIDTH-1];
  assign a_mag     = a_neg ? -dividend : dividend;
  assign b_mag     = b_neg ? -divisor : divisor;
  assign zero_in   = (divisor == '0);
  assign accept    = start & (state != DIV_RUN);
  assign last_iter = (state == DIV_RUN) && (cnt_q == CNT_W'(WIDTH - 1));

`ifdef DIV_ZERO_FAST_EN
  assign fast_zero = zero_in;
  assign div_zero  = done & dz_q;
`else
  assign fast_zero = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (div_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DIV_IDLE;
    else        state <= state_nxt;
  end

  // busy covers the issue cycle so the decoder stalls before the FSM leaves IDLE/DONE.
  always_comb begin
    state_nxt = state;
    busy      = (state == DIV_RUN) | start;
    done      = (state == DIV_DONE);
    state_dbg = state;
    case (state)
      DIV_IDLE, DIV_DONE: begin
        if (start) state_nxt = fast_zero ? DIV_DONE : DIV_RUN;
        else       state_nxt = DIV_IDLE;
      end
      DIV_RUN: begin
        if (last_iter) state_nxt = DIV_DONE;
      end
      default: state_nxt = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      neg_quo   <= 1'b0;
      neg_rem   <= 1'b0;
      dz_q      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      rem_q   <= '0;
      quo_q   <= a_mag;
      div_q   <= b_mag;
      cnt_q   <= '0;
      neg_quo <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      dz_q    <= zero_in;
      if (fast_zero) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state == DIV_RUN) begin
      rem_q <= step_rem;
      quo_q <= step_quo;
      cnt_q <= cnt_q + CNT_W'(1);
      // Divide-by-zero: the iterations leave |dividend| as remainder, so the
      // remainder fix-up restores the original dividend; only the quotient is forced.
      if (last_iter) begin
        quotient  <= dz_q ? '1 : (neg_quo ? -step_quo : step_quo);
        remainder <= neg_rem ? -step_rem : step_rem;
      end
    end
  end

endmodule
